// File: rtl/clksw_pkg.sv
// rtl/clksw_pkg.sv - shared types and helpers for the clock-switch sequencer
package clksw_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENABLE,
    ST_SETTLE,
    ST_SWITCH,
    ST_OFF,
    ST_FAIL,
    ST_DONE
  } state_e;

  // One-hot encoding of a source index, matching the src_en/vld bit order
  function automatic logic [1:0] ONEHOT(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, resets to zero
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] meta_d;
  logic [W-1:0] sync_q;
  logic [W-1:0] sync_d;

  // Shift the asynchronous input through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clksw_seq.sv
// rtl/clksw_seq.sv - request sequencer for the two-source glitch-free clock switch
module clksw_seq
  import clksw_pkg::*;
#(
  parameter logic        INIT     = 1'b0,
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic        AUTO_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_src,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic       cur_src,
  output logic       sel,
  output logic [1:0] src_en,
  input  logic [1:0] src_rdy,
  input  logic [1:0] vld
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0] rdy_s;
  logic [1:0] vld_s;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tgt_q,     tgt_d;
  logic             old_q,     old_d;
  logic             sel_q,     sel_d;
  logic             cur_src_q, cur_src_d;
  logic [1:0]       src_en_q,  src_en_d;
  logic             ack_q,     ack_d;
  logic             err_q,     err_d;
  logic             busy_q,    busy_d;

  sync2 #(.W(2)) u_sync_rdy (
    .clk (clk),
    .rst (rst),
    .d   (src_rdy),
    .q   (rdy_s)
  );

  sync2 #(.W(2)) u_sync_vld (
    .clk (clk),
    .rst (rst),
    .d   (vld),
    .q   (vld_s)
  );

  // Saturating increment so a stalled wait can never wrap past the timeout compare
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Next-state, counter and output decode for the switch sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    tgt_d     = tgt_q;
    old_d     = old_q;
    sel_d     = sel_q;
    cur_src_d = cur_src_q;
    src_en_d  = src_en_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req) begin
          err_d = 1'b0;
          if (req_src == cur_src_q) begin
            state_d = ST_DONE;
          end else begin
            tgt_d             = req_src;
            old_d             = cur_src_q;
            src_en_d[req_src] = 1'b1;
            state_d           = ST_ENABLE;
          end
        end
      end
      ST_ENABLE: begin
        if (rdy_s[tgt_q]) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_FAIL;
        end
      end
      ST_SETTLE: begin
        // Losing lock mid-settle restarts the wait for ready
        if (!rdy_s[tgt_q]) begin
          cnt_d   = '0;
          state_d = ST_ENABLE;
        end else if (cnt_q == SETTLE_LAST) begin
          sel_d   = tgt_q;
          cnt_d   = '0;
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        if (vld_s == ONEHOT(tgt_q)) begin
          cur_src_d = tgt_q;
          state_d   = ST_OFF;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_FAIL;
        end
      end
      ST_OFF: begin
        if (AUTO_OFF) begin
          src_en_d[old_q] = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_FAIL: begin
        // Fall back to the old source; its enable was never dropped
        sel_d           = old_q;
        src_en_d[tgt_q] = 1'b0;
        err_d           = 1'b1;
        state_d         = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_d  = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // FSM, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tgt_q     <= INIT;
      old_q     <= INIT;
      sel_q     <= INIT;
      cur_src_q <= INIT;
      src_en_q  <= ONEHOT(INIT);
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      old_q     <= old_d;
      sel_q     <= sel_d;
      cur_src_q <= cur_src_d;
      src_en_q  <= src_en_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign cur_src = cur_src_q;
  assign sel     = sel_q;
  assign src_en  = src_en_q;

endmodule

// File: tb/tb_clksw_seq.sv
// tb/tb_clksw_seq.sv - directed self-checking bench for clksw_seq
module tb_clksw_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       req_src;
  logic [1:0] src_rdy;
  logic [1:0] vld;

  logic       a_ack, a_err, a_busy, a_cur_src, a_sel;
  logic [1:0] a_src_en;
  logic       b_ack, b_err, b_busy, b_cur_src, b_sel;
  logic [1:0] b_src_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clksw_seq #(.INIT(1'b0), .SETTLE(16), .TIMEOUT(64), .AUTO_OFF(1'b1)) u_a (
    .clk(clk), .rst(rst), .req(req), .req_src(req_src),
    .ack(a_ack), .err(a_err), .busy(a_busy), .cur_src(a_cur_src),
    .sel(a_sel), .src_en(a_src_en), .src_rdy(src_rdy), .vld(vld)
  );

  clksw_seq #(.INIT(1'b0), .SETTLE(16), .TIMEOUT(64), .AUTO_OFF(1'b0)) u_b (
    .clk(clk), .rst(rst), .req(req), .req_src(req_src),
    .ack(b_ack), .err(b_err), .busy(b_busy), .cur_src(b_cur_src),
    .sel(b_sel), .src_en(b_src_en), .src_rdy(src_rdy), .vld(vld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 1'b0; req_src = 1'b0; src_rdy = 2'b01; vld = 2'b01;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (a_sel !== 1'b0) begin n_err++; $display("FAIL reset_sel: got %b want 0", a_sel); end
    n_cmp++; if (a_src_en !== 2'b01) begin n_err++; $display("FAIL reset_src_en: got %b want 01", a_src_en); end
    n_cmp++; if (a_cur_src !== 1'b0) begin n_err++; $display("FAIL reset_cur_src: got %b want 0", a_cur_src); end
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", a_ack); end
    n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", a_err); end
    n_cmp++; if ({b_sel, b_src_en, b_cur_src, b_busy, b_ack, b_err} !== 7'b0_01_0000) begin
      n_err++; $display("FAIL reset_b_outputs: got %b want 0010000", {b_sel, b_src_en, b_cur_src, b_busy, b_ack, b_err});
    end
  endtask

  task automatic test_switch();
    apply_reset();
    req = 1'b1; req_src = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL sw_busy_accept: got %b want 1", a_busy); end
    n_cmp++; if (a_src_en !== 2'b11) begin n_err++; $display("FAIL sw_src_en_accept: got %b want 11", a_src_en); end
    repeat (5) tick();
    src_rdy = 2'b11;
    // two synchronizer stages + one edge into SETTLE, then 16 settle cycles
    repeat (18) tick();
    n_cmp++; if (a_sel !== 1'b0) begin n_err++; $display("FAIL sw_sel_early: got %b want 0", a_sel); end
    tick();
    n_cmp++; if (a_sel !== 1'b1) begin n_err++; $display("FAIL sw_sel_on_time: got %b want 1", a_sel); end
    repeat (6) tick();
    vld = 2'b10;
    repeat (3) tick();
    n_cmp++; if (a_cur_src !== 1'b1) begin n_err++; $display("FAIL sw_cur_src: got %b want 1", a_cur_src); end
    n_cmp++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL sw_ack_early: got %b want 0", a_ack); end
    tick();
    n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL sw_ack: got %b want 1", a_ack); end
    n_cmp++; if (a_src_en !== 2'b10) begin n_err++; $display("FAIL sw_src_en_done: got %b want 10", a_src_en); end
    n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL sw_err: got %b want 0", a_err); end
    n_cmp++; if (b_src_en !== 2'b11) begin n_err++; $display("FAIL sw_noautooff_src_en: got %b want 11", b_src_en); end
    tick();
    n_cmp++; if ({a_ack, a_busy} !== 2'b00) begin n_err++; $display("FAIL sw_ack_busy_after: got %b want 00", {a_ack, a_busy}); end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 1'b1; req_src = 1'b1;
    tick();
    req = 1'b0;
    repeat (64) tick();
    n_cmp++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL to_ack_early: got %b want 0", a_ack); end
    tick();
    n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL to_ack: got %b want 1", a_ack); end
    n_cmp++; if (a_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", a_err); end
    n_cmp++; if (a_src_en !== 2'b01) begin n_err++; $display("FAIL to_src_en: got %b want 01", a_src_en); end
    n_cmp++; if ({a_sel, a_cur_src} !== 2'b00) begin n_err++; $display("FAIL to_sel_cur: got %b want 00", {a_sel, a_cur_src}); end
    tick();
    n_cmp++; if ({a_ack, a_busy, a_err} !== 3'b001) begin n_err++; $display("FAIL to_after: got %b want 001", {a_ack, a_busy, a_err}); end
  endtask

  task automatic test_stuck();
    int n;
    apply_reset();
    src_rdy = 2'b11;
    tick(); tick(); tick();
    req = 1'b1; req_src = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (a_sel !== 1'b1 && n < 60) begin tick(); n++; end
    n_cmp++; if (a_sel !== 1'b1) begin n_err++; $display("FAIL stuck_sel_wait: got %b want 1", a_sel); end
    repeat (64) tick();
    n_cmp++; if ({a_ack, a_sel} !== 2'b01) begin n_err++; $display("FAIL stuck_before_fail: got %b want 01", {a_ack, a_sel}); end
    tick();
    n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL stuck_ack: got %b want 1", a_ack); end
    n_cmp++; if (a_sel !== 1'b0) begin n_err++; $display("FAIL stuck_sel_back: got %b want 0", a_sel); end
    n_cmp++; if (a_src_en !== 2'b01) begin n_err++; $display("FAIL stuck_src_en: got %b want 01", a_src_en); end
    n_cmp++; if ({a_err, a_cur_src} !== 2'b10) begin n_err++; $display("FAIL stuck_err_cur: got %b want 10", {a_err, a_cur_src}); end
    tick();
    req = 1'b1; req_src = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if ({a_err, a_busy} !== 2'b01) begin n_err++; $display("FAIL retry_err_clear: got %b want 01", {a_err, a_busy}); end
    n = 0;
    while (a_sel !== 1'b1 && n < 60) begin tick(); n++; end
    n_cmp++; if (a_sel !== 1'b1) begin n_err++; $display("FAIL retry_sel_wait: got %b want 1", a_sel); end
    repeat (6) tick();
    vld = 2'b10;
    n = 0;
    while (a_ack !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL retry_ack_wait: got %b want 1", a_ack); end
    n_cmp++; if ({a_cur_src, a_src_en, a_err} !== 4'b1_10_0) begin n_err++; $display("FAIL retry_done: got %b want 1100", {a_cur_src, a_src_en, a_err}); end
    tick();
  endtask

  task automatic test_noop_and_ignore();
    int n;
    int acks;
    req = 1'b1; req_src = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if ({a_ack, a_busy} !== 2'b11) begin n_err++; $display("FAIL noop_ack_busy: got %b want 11", {a_ack, a_busy}); end
    n_cmp++; if ({a_sel, a_src_en} !== 3'b1_10) begin n_err++; $display("FAIL noop_unchanged: got %b want 110", {a_sel, a_src_en}); end
    tick();
    n_cmp++; if ({a_ack, a_busy} !== 2'b00) begin n_err++; $display("FAIL noop_after: got %b want 00", {a_ack, a_busy}); end
    req = 1'b1; req_src = 1'b0;
    tick();
    req = 1'b0;
    acks = 0;
    n_cmp++; if ({a_busy, a_src_en} !== 3'b1_11) begin n_err++; $display("FAIL b2b_accept: got %b want 111", {a_busy, a_src_en}); end
    tick(); tick();
    req = 1'b1; req_src = 1'b1;
    tick();
    req = 1'b0;
    for (n = 0; n < 80; n++) begin
      if (a_ack === 1'b1) acks++;
      if (a_sel === 1'b0) vld = 2'b01;
      tick();
    end
    n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL b2b_ack_count: got %0d want 1", acks); end
    n_cmp++; if ({a_cur_src, a_src_en, a_busy} !== 4'b0_01_0) begin n_err++; $display("FAIL b2b_final: got %b want 0010", {a_cur_src, a_src_en, a_busy}); end
  endtask

  task automatic test_reset_mid_switch();
    int n;
    src_rdy = 2'b11; vld = 2'b01;
    req = 1'b1; req_src = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (a_sel !== 1'b1 && n < 60) begin tick(); n++; end
    n_cmp++; if (a_sel !== 1'b1) begin n_err++; $display("FAIL rstmid_sel_wait: got %b want 1", a_sel); end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if ({a_sel, a_src_en, a_cur_src, a_busy, a_ack, a_err} !== 7'b0_01_0000) begin
      n_err++; $display("FAIL rstmid_outputs: got %b want 0010000", {a_sel, a_src_en, a_cur_src, a_busy, a_ack, a_err});
    end
    n_cmp++; if (b_src_en !== 2'b01) begin n_err++; $display("FAIL rstmid_b_src_en: got %b want 01", b_src_en); end
    rst = 1'b0;
    repeat (3) tick();
    req = 1'b1; req_src = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (a_sel !== 1'b1 && n < 60) begin tick(); n++; end
    n_cmp++; if (a_sel !== 1'b1) begin n_err++; $display("FAIL post_rst_sel_wait: got %b want 1", a_sel); end
    repeat (6) tick();
    vld = 2'b10;
    n = 0;
    while (a_ack !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL post_rst_ack_wait: got %b want 1", a_ack); end
    n_cmp++; if ({a_cur_src, a_src_en, a_err} !== 4'b1_10_0) begin n_err++; $display("FAIL post_rst_done: got %b want 1100", {a_cur_src, a_src_en, a_err}); end
    n_cmp++; if ({b_cur_src, b_src_en, b_ack} !== 4'b1_11_1) begin n_err++; $display("FAIL post_rst_noautooff: got %b want 1111", {b_cur_src, b_src_en, b_ack}); end
    tick();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_src = 1'b0; src_rdy = 2'b01; vld = 2'b01;
    test_reset();
    test_switch();
    test_timeout();
    test_stuck();
    test_noop_and_ignore();
    test_reset_mid_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
